// File: rtl/break_scan_controller.sv
// break_scan_controller
// Scores the candidate variables of one unsatisfied clause through a single
// shared break-value evaluation path. Candidates are evaluated one at a time.
// The candidate with the minimum break value is kept. The scan ends early when
// a candidate has a break value of zero.
module break_scan_controller #(
    parameter int NUM_CANDIDATES   = 3,
    parameter int VAR_BITS         = 8,
    parameter int NUM_CLAUSES_BITS = 5,
    parameter int IDX_BITS         = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [NUM_CANDIDATES*VAR_BITS-1:0] cand_vars,
    input  logic [NUM_CANDIDATES-1:0]          cand_valid,
    output logic                               eval_req,
    output logic [VAR_BITS-1:0]                eval_var,
    input  logic                               eval_gnt,
    input  logic                               bv_valid,
    input  logic [NUM_CLAUSES_BITS-1:0]        break_value,
    output logic                               busy,
    output logic                               done,
    output logic                               no_candidate,
    output logic [VAR_BITS-1:0]                best_var,
    output logic [IDX_BITS-1:0]                best_idx,
    output logic [NUM_CLAUSES_BITS-1:0]        best_break
);

    // Index space is padded to a power of two so that any idx value selects a defined slot.
    localparam int SLOTS = 2 ** IDX_BITS;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                              state_reg, state_next;
    logic [NUM_CANDIDATES*VAR_BITS-1:0]  cand_vars_reg, cand_vars_next;
    logic [NUM_CANDIDATES-1:0]           cand_valid_reg, cand_valid_next;
    logic [IDX_BITS-1:0]                 idx_reg, idx_next;
    logic                                have_best_reg, have_best_next;
    logic                                eval_req_reg;
    logic [VAR_BITS-1:0]                 eval_var_reg, eval_var_next;
    logic                                busy_reg;
    logic                                done_reg;
    logic                                no_candidate_reg, no_candidate_next;
    logic [VAR_BITS-1:0]                 best_var_reg, best_var_next;
    logic [IDX_BITS-1:0]                 best_idx_reg, best_idx_next;
    logic [NUM_CLAUSES_BITS-1:0]         best_break_reg, best_break_next;

    // Candidate IDs as arrays: straight from the input (for the start cycle) and latched.
    logic [VAR_BITS-1:0] in_cand  [SLOTS];
    logic [VAR_BITS-1:0] lat_cand [SLOTS];

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        if (gi < NUM_CANDIDATES) begin : g_real
            assign in_cand[gi]  = cand_vars[gi*VAR_BITS +: VAR_BITS];
            assign lat_cand[gi] = cand_vars_reg[gi*VAR_BITS +: VAR_BITS];
        end else begin : g_pad
            assign in_cand[gi]  = '0;
            assign lat_cand[gi] = '0;
        end
    end

    logic                first_found;
    logic [IDX_BITS-1:0] first_idx;
    logic                next_found;
    logic [IDX_BITS-1:0] next_idx;

    // Lowest valid candidate in the incoming mask (used when a start is accepted).
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (!first_found && cand_valid[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_BITS'(i);
            end
        end
    end

    // Next valid latched candidate strictly above the current index.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (!next_found && cand_valid_reg[i] && (i > int'(idx_reg))) begin
                next_found = 1'b1;
                next_idx   = IDX_BITS'(i);
            end
        end
    end

    // Next-state and next-output logic; abort overrides every transition and leaves results untouched.
    always_comb begin
        state_next        = state_reg;
        cand_vars_next    = cand_vars_reg;
        cand_valid_next   = cand_valid_reg;
        idx_next          = idx_reg;
        have_best_next    = have_best_reg;
        eval_var_next     = eval_var_reg;
        no_candidate_next = no_candidate_reg;
        best_var_next     = best_var_reg;
        best_idx_next     = best_idx_reg;
        best_break_next   = best_break_reg;

        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cand_vars_next  = cand_vars;
                        cand_valid_next = cand_valid;
                        have_best_next  = 1'b0;
                        if (!first_found) begin
                            no_candidate_next = 1'b1;
                            state_next        = DONE;
                        end else begin
                            no_candidate_next = 1'b0;
                            idx_next          = first_idx;
                            eval_var_next     = in_cand[first_idx];
                            state_next        = REQ;
                        end
                    end
                end
                REQ: begin
                    if (eval_gnt) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (bv_valid) begin
                        // Strict compare: on a tie the earlier (lower index) candidate stays.
                        if (!have_best_reg || (break_value < best_break_reg)) begin
                            have_best_next  = 1'b1;
                            best_var_next   = lat_cand[idx_reg];
                            best_idx_next   = idx_reg;
                            best_break_next = break_value;
                        end
                        if (break_value == '0) begin
                            state_next = DONE;
                        end else if (next_found) begin
                            idx_next      = next_idx;
                            eval_var_next = lat_cand[next_idx];
                            state_next    = REQ;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers; status outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cand_vars_reg    <= '0;
            cand_valid_reg   <= '0;
            idx_reg          <= '0;
            have_best_reg    <= 1'b0;
            eval_req_reg     <= 1'b0;
            eval_var_reg     <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            no_candidate_reg <= 1'b0;
            best_var_reg     <= '0;
            best_idx_reg     <= '0;
            best_break_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            cand_vars_reg    <= cand_vars_next;
            cand_valid_reg   <= cand_valid_next;
            idx_reg          <= idx_next;
            have_best_reg    <= have_best_next;
            eval_req_reg     <= (state_next == REQ);
            eval_var_reg     <= eval_var_next;
            busy_reg         <= (state_next != IDLE);
            done_reg         <= (state_next == DONE);
            no_candidate_reg <= no_candidate_next;
            best_var_reg     <= best_var_next;
            best_idx_reg     <= best_idx_next;
            best_break_reg   <= best_break_next;
        end
    end

    assign eval_req     = eval_req_reg;
    assign eval_var     = eval_var_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign no_candidate = no_candidate_reg;
    assign best_var     = best_var_reg;
    assign best_idx     = best_idx_reg;
    assign best_break   = best_break_reg;

endmodule

// File: tb/tb_break_scan_controller.sv
// Self-checking bench for break_scan_controller: table of directed scans driven
// through a small datapath responder, plus hand-written abort/reset/hold sequences.
module tb_break_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [23:0] cand_vars;
    logic [2:0]  cand_valid;
    logic        eval_req;
    logic [7:0]  eval_var;
    logic        eval_gnt, bv_valid;
    logic [4:0]  break_value;
    logic        busy, done, no_candidate;
    logic [7:0]  best_var;
    logic [1:0]  best_idx;
    logic [4:0]  best_break;

    int checks   = 0;
    int failures = 0;

    break_scan_controller #(
        .NUM_CANDIDATES(3), .VAR_BITS(8), .NUM_CLAUSES_BITS(5), .IDX_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cand_vars(cand_vars), .cand_valid(cand_valid),
        .eval_req(eval_req), .eval_var(eval_var), .eval_gnt(eval_gnt),
        .bv_valid(bv_valid), .break_value(break_value),
        .busy(busy), .done(done), .no_candidate(no_candidate),
        .best_var(best_var), .best_idx(best_idx), .best_break(best_break)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [23:0] vars;
        logic [14:0] breaks;
        int          gnt_delay;
        int          bv_delay;
        bit          spur;
        bit          restart;
        int          exp_done;
        int          exp_nreq;
        logic [23:0] exp_seq;
        logic [7:0]  exp_var;
        logic [1:0]  exp_idx;
        logic [4:0]  exp_break;
        bit          exp_nocand;
        bit          chk_best;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [2:0] valid, input logic [23:0] vars,
                                input logic [14:0] breaks, input int gd, input int bd,
                                input bit spur, input bit restart, input int ed, input int en,
                                input logic [23:0] eseq, input logic [7:0] ev,
                                input logic [1:0] ei, input logic [4:0] eb,
                                input bit enc, input bit cb);
        vec_t v;
        v.valid = valid; v.vars = vars; v.breaks = breaks;
        v.gnt_delay = gd; v.bv_delay = bd; v.spur = spur; v.restart = restart;
        v.exp_done = ed; v.exp_nreq = en; v.exp_seq = eseq;
        v.exp_var = ev; v.exp_idx = ei; v.exp_break = eb;
        v.exp_nocand = enc; v.chk_best = cb;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Runs one scan starting at the next falling edge (cycle 0 = start cycle),
    // acting as the evaluation datapath with the vector's grant/result delays.
    task automatic run_vec(input vec_t v, input int n);
        int          done_cyc;
        int          nreq;
        int          req_age;
        int          wait_age;
        bit          in_req;
        bit          outstanding;
        bit          granted_prev;
        bit          proto_ok;
        logic [7:0]  held_var;
        logic [23:0] seq;
        logic [4:0]  bvv;
        done_cyc = -1; nreq = 0; req_age = 0; wait_age = 0;
        in_req = 0; outstanding = 0; granted_prev = 0; proto_ok = 1;
        held_var = '0; seq = '0;

        @(negedge clk);
        cand_vars = v.vars; cand_valid = v.valid; start = 1'b1;
        eval_gnt = 1'b0; bv_valid = 1'b0; break_value = '0;

        for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            eval_gnt = 1'b0; bv_valid = 1'b0; break_value = '0;
            if (v.restart && cyc == 2) begin
                start = 1'b1; cand_vars = {8'd99, 8'd98, 8'd97}; cand_valid = 3'b111;
            end
            if (!busy) proto_ok = 0;
            if (done) done_cyc = cyc;
            if (eval_req && (granted_prev || outstanding)) proto_ok = 0;
            granted_prev = 0;
            if (eval_req) begin
                if (!in_req) begin
                    in_req = 1; req_age = 0; held_var = eval_var;
                    if (nreq < 3) seq[nreq*8 +: 8] = eval_var;
                    nreq++;
                end else begin
                    if (eval_var != held_var) proto_ok = 0;
                    req_age++;
                end
                if (req_age == v.gnt_delay) begin
                    eval_gnt = 1'b1; in_req = 0; outstanding = 1;
                    wait_age = -1; granted_prev = 1;
                end else if (v.spur && req_age == 1) begin
                    bv_valid = 1'b1; break_value = '0;
                end
            end else if (outstanding) begin
                wait_age++;
                if (wait_age == v.bv_delay) begin
                    bvv = 5'd31;
                    for (int i = 0; i < 3; i++)
                        if (v.vars[i*8 +: 8] == held_var) bvv = v.breaks[i*5 +: 5];
                    bv_valid = 1'b1; break_value = bvv; outstanding = 0;
                end
            end
        end
        eval_gnt = 1'b0; bv_valid = 1'b0; break_value = '0;

        $display("vec %0d: requests=%0d done_cycle=%0d best_var=%0d best_idx=%0d best_break=%0d no_candidate=%0d",
                 n, nreq, done_cyc, best_var, best_idx, best_break, no_candidate);
        chk($sformatf("vec%0d_done_cycle", n), done_cyc, v.exp_done);
        chk($sformatf("vec%0d_num_requests", n), nreq, v.exp_nreq);
        chk($sformatf("vec%0d_eval_var_sequence", n), int'(seq), int'(v.exp_seq));
        chk($sformatf("vec%0d_protocol", n), int'(proto_ok), 1);
        chk($sformatf("vec%0d_no_candidate", n), int'(no_candidate), int'(v.exp_nocand));
        if (v.chk_best) begin
            chk($sformatf("vec%0d_best_var", n), int'(best_var), int'(v.exp_var));
            chk($sformatf("vec%0d_best_idx", n), int'(best_idx), int'(v.exp_idx));
            chk($sformatf("vec%0d_best_break", n), int'(best_break), int'(v.exp_break));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int saw_done;
        // valid, vars{c2,c1,c0}, breaks{c2,c1,c0}, gnt_d, bv_d, spur, restart,
        // done_cycle, nreq, seq{r2,r1,r0}, best var/idx/break, no_candidate, check_best
        vecs[0] = mk(3'b111, {8'd30, 8'd20, 8'd10}, {5'd3, 5'd2, 5'd4}, 0, 0, 0, 0,
                     7, 3, {8'd30, 8'd20, 8'd10}, 8'd20, 2'd1, 5'd2, 0, 1);
        vecs[1] = mk(3'b111, {8'd30, 8'd20, 8'd10}, {5'd9, 5'd0, 5'd3}, 0, 0, 0, 0,
                     5, 2, {8'd0, 8'd20, 8'd10}, 8'd20, 2'd1, 5'd0, 0, 1);
        vecs[2] = mk(3'b101, {8'd30, 8'd20, 8'd10}, {5'd5, 5'd9, 5'd5}, 0, 0, 0, 0,
                     5, 2, {8'd0, 8'd30, 8'd10}, 8'd10, 2'd0, 5'd5, 0, 1);
        vecs[3] = mk(3'b000, {8'd30, 8'd20, 8'd10}, {5'd0, 5'd0, 5'd0}, 0, 0, 0, 0,
                     1, 0, 24'd0, 8'd0, 2'd0, 5'd0, 1, 0);
        vecs[4] = mk(3'b111, {8'd30, 8'd20, 8'd10}, {5'd3, 5'd3, 5'd6}, 3, 4, 1, 1,
                     28, 3, {8'd30, 8'd20, 8'd10}, 8'd20, 2'd1, 5'd3, 0, 1);
        vecs[5] = mk(3'b110, {8'd60, 8'd50, 8'd40}, {5'd0, 5'd1, 5'd9}, 0, 0, 0, 0,
                     5, 2, {8'd0, 8'd60, 8'd50}, 8'd60, 2'd2, 5'd0, 0, 1);

        reset = 1'b1; start = 1'b0; abort = 1'b0; cand_vars = '0; cand_valid = '0;
        eval_gnt = 1'b0; bv_valid = 1'b0; break_value = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_eval_req", int'(eval_req), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_no_candidate", int'(no_candidate), 0);
        chk("reset_eval_var", int'(eval_var), 0);
        chk("reset_best_var", int'(best_var), 0);
        chk("reset_best_idx", int'(best_idx), 0);
        chk("reset_best_break", int'(best_break), 0);
        reset = 1'b0;

        // Table-driven scans, each starting the cycle after the previous done.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Empty mask again, then outputs must hold while idle.
        run_vec(vecs[3], 6);
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || eval_req) saw_done = 1;
        end
        $display("hold after empty scan: no_candidate=%0d", no_candidate);
        chk("hold_idle_quiet", saw_done, 0);
        chk("hold_no_candidate", int'(no_candidate), 1);

        // Abort in WAIT of the second candidate, then a late result.
        @(negedge clk);
        cand_vars = {8'd30, 8'd20, 8'd10}; cand_valid = 3'b111; start = 1'b1;
        @(negedge clk); start = 1'b0; eval_gnt = 1'b1;                      // cycle 1
        @(negedge clk); eval_gnt = 1'b0; bv_valid = 1'b1; break_value = 5'd7; // cycle 2
        @(negedge clk); bv_valid = 1'b0; break_value = '0; eval_gnt = 1'b1; // cycle 3
        chk("abort_second_req_var", int'(eval_var), 20);
        @(negedge clk); eval_gnt = 1'b0; abort = 1'b1;                      // cycle 4
        chk("abort_in_wait_busy", int'(busy), 1);
        @(negedge clk); abort = 1'b0; bv_valid = 1'b1; break_value = 5'd0;  // cycle 5
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_eval_req_low", int'(eval_req), 0);
        saw_done = int'(done);
        @(negedge clk); bv_valid = 1'b0;
        repeat (3) begin
            if (done || busy) saw_done = 1;
            @(negedge clk);
        end
        $display("abort: best_var=%0d best_idx=%0d best_break=%0d", best_var, best_idx, best_break);
        chk("abort_no_done", saw_done, 0);
        chk("abort_best_var", int'(best_var), 10);
        chk("abort_best_idx", int'(best_idx), 0);
        chk("abort_best_break", int'(best_break), 7);

        // A fresh scan still works after the abort.
        run_vec(vecs[0], 7);

        // Asynchronous reset while in REQ.
        @(negedge clk);
        cand_vars = {8'd30, 8'd20, 8'd10}; cand_valid = 3'b111; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("pre_reset_eval_req", int'(eval_req), 1);
        #2 reset = 1'b1;
        #1;
        $display("async reset: eval_req=%0d busy=%0d best_var=%0d", eval_req, busy, best_var);
        chk("async_reset_eval_req", int'(eval_req), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_best_var", int'(best_var), 0);
        chk("async_reset_eval_var", int'(eval_var), 0);
        @(negedge clk); reset = 1'b0;

        // Recovery after reset.
        run_vec(vecs[2], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
